// File: rtl/regfile_wb_arbiter_pkg.sv
// rtl/regfile_wb_arbiter_pkg.sv - shared constants and helpers for the regfile write-port arbiter
package regfile_wb_arbiter_pkg;

  localparam int DW_DEF   = 32;
  localparam int AW_DEF   = 5;
  localparam int REG_ZERO = 0;

  // Width of an occupancy counter that must represent 0..depth inclusive
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/wb_fifo.sv
// rtl/wb_fifo.sv - in-order addr+data FIFO with per-entry visibility for hazard compares
module wb_fifo
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 4,
  localparam int CW   = count_width(DEPTH),
  localparam int PW   = $clog2(DEPTH)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic [AW-1:0]               push_addr,
  input  logic [DW-1:0]               push_data,
  input  logic                        pop,
  output logic [AW-1:0]               head_addr,
  output logic [DW-1:0]               head_data,
  output logic [CW-1:0]               count,
  output logic                        full,
  output logic                        empty,
  output logic [DEPTH-1:0]            entry_valid,
  output logic [DEPTH-1:0][AW-1:0]    entry_addr
);

  logic [DEPTH-1:0][AW-1:0] mem_addr;
  logic [DEPTH-1:0][DW-1:0] mem_data;
  logic [PW-1:0]            rd_ptr;
  logic [PW-1:0]            wr_ptr;
  logic                     do_push;
  logic                     do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign head_addr  = mem_addr[rd_ptr];
  assign head_data  = mem_data[rd_ptr];
  assign entry_addr = mem_addr;

  // Storage write; contents need no reset because validity comes from the pointers
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wr_ptr] <= push_addr;
      mem_data[wr_ptr] <= push_data;
    end
  end

  // Pointer and occupancy bookkeeping; reset discards everything queued
  always_ff @(posedge clk) begin
    if (!reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // A slot is live when its distance from the head is below the occupancy
  always_comb begin
    logic [PW-1:0] off;
    entry_valid = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rd_ptr;
      entry_valid[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - merges pipeline writeback and queued multicycle results onto one regfile write port
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int DW           = DW_DEF,
  parameter int AW           = AW_DEF,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 8,
  localparam int CW          = count_width(DEPTH),
  localparam int SW          = $clog2(STARVE_LIMIT + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pri_valid,
  input  logic [AW-1:0] pri_addr,
  input  logic [DW-1:0] pri_data,
  input  logic          sec_valid,
  output logic          sec_ready,
  input  logic [AW-1:0] sec_addr,
  input  logic [DW-1:0] sec_data,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_hit1,
  output logic          q_hit2,
  output logic          we,
  output logic [AW-1:0] writeaddr,
  output logic [DW-1:0] writedata,
  output logic          pipe_stall,
  output logic [CW-1:0] fifo_count,
  output logic          err_collision
);

  logic                     pri_use;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [AW-1:0]            head_addr;
  logic [DW-1:0]            head_data;
  logic [DEPTH-1:0]         entry_valid;
  logic [DEPTH-1:0][AW-1:0] entry_addr;
  logic [SW-1:0]            starve_cnt;
  logic [SW-1:0]            starve_next;

  // Register zero is hardwired, so a primary write to it does not occupy the port
  assign pri_use   = pri_valid && (pri_addr != AW'(REG_ZERO));
  assign sec_ready = reset && !fifo_full;
  assign fifo_push = sec_valid && sec_ready && (sec_addr != AW'(REG_ZERO));
  assign fifo_pop  = reset && !fifo_empty && !pri_use;

  wb_fifo #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .reset       (reset),
    .push        (fifo_push),
    .push_addr   (sec_addr),
    .push_data   (sec_data),
    .pop         (fifo_pop),
    .head_addr   (head_addr),
    .head_data   (head_data),
    .count       (fifo_count),
    .full        (fifo_full),
    .empty       (fifo_empty),
    .entry_valid (entry_valid),
    .entry_addr  (entry_addr)
  );

  // Write-port mux: primary has absolute priority, FIFO head fills idle cycles
  always_comb begin
    we        = 1'b0;
    writeaddr = '0;
    writedata = '0;
    if (reset) begin
      if (pri_use) begin
        we        = 1'b1;
        writeaddr = pri_addr;
        writedata = pri_data;
      end else if (!fifo_empty) begin
        we        = 1'b1;
        writeaddr = head_addr;
        writedata = head_data;
      end
    end
  end

  // Pending-write hits against queued entries only; an entry arriving this cycle is not yet visible
  always_comb begin
    q_hit1 = 1'b0;
    q_hit2 = 1'b0;
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (entry_valid[i] && (entry_addr[i] == q_addr1) && (q_addr1 != AW'(REG_ZERO))) q_hit1 = 1'b1;
        if (entry_valid[i] && (entry_addr[i] == q_addr2) && (q_addr2 != AW'(REG_ZERO))) q_hit2 = 1'b1;
      end
    end
  end

  // Starvation count: how long the head has waited behind the primary, saturating at the limit
  always_comb begin
    starve_next = starve_cnt;
    if (fifo_empty || fifo_pop) begin
      starve_next = '0;
    end else if (starve_cnt < SW'(STARVE_LIMIT)) begin
      starve_next = starve_cnt + SW'(1);
    end
  end

  // Starve counter, stall request and sticky collision flag
  always_ff @(posedge clk) begin
    if (!reset) begin
      starve_cnt    <= '0;
      pipe_stall    <= 1'b0;
      err_collision <= 1'b0;
    end else begin
      starve_cnt <= starve_next;
      pipe_stall <= (starve_next == SW'(STARVE_LIMIT));
      if (pipe_stall && pri_use) err_collision <= 1'b1;
    end
  end

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-port arbiter directly upstream of the 32x32 register file. It merges two result sources into the regfile's single write port (we / writeaddr / writedata).
- Primary source: the pipeline writeback stage. It is never back-pressured.
- Secondary source: multicycle units such as mul/div. It uses a valid/ready handshake into a small FIFO, which drains into idle write-port cycles.
- Supplies pending-write hit flags so hazard logic can stall reads of registers still queued.

Parameters:
- DW, 32, data width
- AW, 5, register address width
- DEPTH, 4, secondary FIFO entries (power of 2, >=2)
- STARVE_LIMIT, 8, cycles the FIFO head may wait before pipe_stall is requested

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-low
- pri_valid  in  1  pipeline writeback valid this cycle
- pri_addr  in  AW  pipeline destination register
- pri_data  in  DW  pipeline result
- sec_valid  in  1  secondary result valid
- sec_ready  out  1  FIFO can accept this cycle
- sec_addr  in  AW  secondary destination register
- sec_data  in  DW  secondary result
- q_addr1  in  AW  hazard query address (read port 1)
- q_addr2  in  AW  hazard query address (read port 2)
- q_hit1  out  1  q_addr1 matches a queued FIFO entry
- q_hit2  out  1  q_addr2 matches a queued FIFO entry
- we  out  1  regfile write enable
- writeaddr  out  AW  regfile write address
- writedata  out  DW  regfile write data
- pipe_stall  out  1  request that the pipeline withhold pri_valid
- fifo_count  out  clog2(DEPTH)+1  queued entries
- err_collision  out  1  sticky: pri_valid seen while pipe_stall=1

Behaviour:
- Reset (reset=0 at posedge):
  - FIFO empty, fifo_count=0, starve counter=0
  - pipe_stall=0, err_collision=0
- While reset=0, outputs are forced: we=0, sec_ready=0, q_hit1=q_hit2=0.
- Write-port arbitration (combinational; the regfile commits at the next posedge):
  - pri_valid=1 and pri_addr!=0: we=1, writeaddr/writedata taken from the primary.
  - Else if FIFO non-empty: we=1 with the FIFO head; the head pops at the posedge.
  - Else we=0. writeaddr/writedata are don't-care; drive 0.
- Primary addr 0 gives we=0 and does not count as port use, so the FIFO head may drain that cycle.
- Handshake:
  - sec_ready = (fifo_count < DEPTH), derived from registered state only.
  - Transfer occurs when sec_valid & sec_ready at the posedge.
  - sec_addr==0 transfers complete but are discarded (not enqueued).
- No bypass: an accepted entry reaches we no earlier than the next cycle (minimum latency 1).
- Push and pop in the same cycle is allowed; fifo_count is unchanged. A full FIFO cannot push (sec_ready=0) even when popping.
- Ordering: the FIFO is strictly in order. No WAW check between sources; hazard logic uses q_hit to prevent it.
- q_hitN=1 when any valid FIFO entry's addr equals q_addrN and q_addrN!=0. It is combinational from FIFO state and excludes the entry being written this cycle.
- Starve counter:
  - Cleared on pop or when the FIFO is empty.
  - Increments each cycle the FIFO is non-empty and the head does not pop; saturates at STARVE_LIMIT.
- pipe_stall (registered):
  - Set at the posedge where the counter reaches STARVE_LIMIT.
  - Cleared at the posedge following a pop, or when the FIFO becomes empty.
- Collision: pipe_stall=1 and pri_valid=1 with pri_addr!=0 means the primary still wins and err_collision sets. It is cleared only by reset.
- Reset asserted mid-operation discards all queued entries. No writes are issued while reset=0.

Decomposition:
- Shared package: DW/AW defaults, register-zero constant, fifo_count width function.
- One sub-module: wb_fifo (DEPTH-entry sync FIFO, addr+data, count, full/empty, per-entry valid vector and addr array exported for the q_hit compares).
- Arbitration, starve counter and hazard compares stay in the top.

Test Plan:
- Reset then idle: reset=0 for 2 cycles with sec_valid=1 -> we=0, sec_ready=0, fifo_count=0, pipe_stall=0; after release, sec_ready=1.
- Primary only: pri_valid=1, addr=5, data=0xDEADBEEF -> same cycle we=1, writeaddr=5, writedata=0xDEADBEEF. With addr=0 -> we=0.
- Secondary drain: sec pushes (7,0x11),(8,0x22) in back-to-back cycles with pri idle -> we=1 for addr 7 then addr 8 on consecutive cycles, first one cycle after acceptance. q_addr1=8 gives q_hit1=1 until addr 8 is written, then 0.
- Full FIFO: pri_valid=1 continuously (addr 3), push 4 entries -> fifo_count=4, sec_ready=0, 5th sec_valid not accepted, no entry lost. Drop pri_valid -> 4 writes in FIFO order.
- Starvation: one entry queued, pri_valid=1 (addr 4) continuously -> pipe_stall=1 after 8 waiting cycles. Hold pri_valid=1 one more cycle -> err_collision=1. Drop pri_valid -> head written, pipe_stall=0 next cycle, err_collision stays 1 until reset.
- Addr-0 secondary and mid-queue reset: sec addr 0 accepted -> fifo_count stays 0. Queue 3 entries, assert reset one cycle -> fifo_count=0, no we after release.
